ladybird_bus_initiator: RTL and testbench
=========================================

# ladybird_bus_initiator

Single-outstanding primary on `ladybird_bus`. It turns a valid/ready command (address, write strobe, write data) into one bus transaction and returns read data or an error on a valid/ready response port. It is the initiating end for secondaries such as the GPIO, timer and UART register blocks, and is used by the debug/loader path and by bench stimulus.

## Interface
Parameters:
- `TIMEOUT`, default 255: cycles `req` may stay high without completion before the transaction is aborted with an error; range 1..65535.
- `CNT_WIDTH`, default `$clog2(TIMEOUT+1)`: width of the timeout counter.

Ports:
- `clk` input, 1: sole clock; all state is updated on the rising edge.
- `rst` input, 1: reset, asynchronous and active-high.
- `bus` modport `ladybird_bus.primary`: drives `req`, `addr[31:0]` and `wstrb[3:0]`; drives `data[31:0]` on writes only; samples `gnt` and `data_gnt`.
- `cmd_valid` input, 1: a command is offered.
- `cmd_ready` output, 1: the initiator can accept a command.
- `cmd_addr` input, 32: byte address.
- `cmd_wstrb` input, 4: byte enables; 0 means read.
- `cmd_wdata` input, 32: write data.
- `rsp_valid` output, 1: a response is held.
- `rsp_ready` input, 1: the consumer accepts the response.
- `rsp_rdata` output, 32: read data; 0 for writes and on error.
- `rsp_err` output, 1: the transaction timed out.

## Operation
- FSM states: IDLE, REQ, RSP. Reset state: IDLE.
- IDLE:
  - `cmd_ready`=1.
  - When `cmd_valid` is high, latch addr, wstrb and wdata, clear the counter, go to REQ.
- REQ:
  - `bus.req`=1; `bus.addr` and `bus.wstrb` come from the latched command.
  - `bus.data` carries the latched wdata when wstrb≠0, otherwise `'z`.
  - Write completes in the first REQ cycle with `bus.gnt`=1: rdata=0, err=0, go to RSP.
  - Read completes in the first REQ cycle with `bus.data_gnt`=1: capture `bus.data` into rdata, err=0, go to RSP. `gnt` alone does not complete a read; `req` stays high until `data_gnt`.
  - Otherwise the counter increments. When the counter equals TIMEOUT-1 and there is no completion that cycle: rdata=0, err=1, go to RSP.
  - Completion wins over timeout in the same cycle.
- RSP:
  - `rsp_valid`=1 with rdata and err stable.
  - When `rsp_ready` is high, go to IDLE.
  - `bus.req`=0 and `bus.data`=`'z`.
- Only one transaction is outstanding; `cmd_ready` is 0 in REQ and RSP.
- Reset values: `bus.req`=0, `bus.addr`=0, `bus.wstrb`=0, `bus.data`=`'z`, `cmd_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- Asserting reset mid-transaction drops `req` immediately (asynchronous) and discards the command and response. No response is produced.

## Timing
- Command handshake at edge T puts `req` high in cycle T+1.
- Zero-wait secondary (completes combinationally in T+1): `rsp_valid` is high from T+2.
- With N wait cycles, `rsp_valid` rises at T+2+N.
- Timeout: `req` is high for exactly TIMEOUT cycles, and `rsp_valid` rises at T+1+TIMEOUT.
- Back-to-back throughput: a response accepted at edge R gives `cmd_ready`=1 in R+1, so the best case is 3 cycles per transaction.
- `bus.req`, `bus.addr`, `bus.wstrb` and the write data come directly from flops. Only the tristate enable decodes state.
- Read data is sampled at the edge that ends the completing cycle. Secondaries may drive `data` combinationally from `req`.

## Structure
- Shared package `ladybird_bus_pkg`:
  - `cmd_t {addr, wstrb, wdata}`
  - `rsp_t {rdata, err}`
  - constant `BUS_DATA_W`=32
- The FSM state enum stays local to the module.
- One sub-module: `ladybird_timeout_counter` (clear, enable, expired at TIMEOUT-1). It is reusable by other primaries.

## Test plan
- Read, zero-wait secondary with `data_gnt` combinational, word 0x0000_0005 at addr 0x4: `req` for 1 cycle, response rdata=0x5, err=0, `rsp_valid` at T+2.
- Write wstrb=0xF, wdata=0xA at addr 0x8, `gnt` held high: `bus.data`=0xA while `req`=1; response rdata=0, err=0; secondary register reads back 0xA.
- Read with `gnt`=1 but `data_gnt` delayed 3 cycles: `req` high 4 cycles, rdata captured on the 4th cycle, `rsp_valid` at T+5.
- TIMEOUT=4, secondary never responds: `req` high exactly 4 cycles, then err=1, rdata=0.
- `rsp_ready` held low 5 cycles: `rsp_valid` and data stay stable, `cmd_ready`=0 throughout, and a second command is not accepted until the cycle after the handshake.
- `rst` pulsed asynchronously mid-REQ: `req` falls before the next edge, `rsp_valid` stays 0, and `cmd_ready` is 1 after release.

Source files
------------

// File: rtl/ladybird_bus_pkg.sv
// Shared types for the ladybird_bus: command/response records and the bus data width.
package ladybird_bus_pkg;

  localparam int unsigned BUS_DATA_W = 32;

  typedef struct packed {
    logic [31:0]           addr;
    logic [3:0]            wstrb;
    logic [BUS_DATA_W-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [BUS_DATA_W-1:0] rdata;
    logic                  err;
  } rsp_t;

endpackage

// File: rtl/ladybird_bus_if.sv
// ladybird_bus signal bundle. The data lines are shared: the primary drives them on writes and
// the secondary drives them on reads.
interface ladybird_bus_if;
  logic        req;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic        gnt;
  logic        data_gnt;
  wire  [31:0] data;

  modport primary (
    output req,
    output addr,
    output wstrb,
    inout  data,
    input  gnt,
    input  data_gnt
  );

  modport secondary (
    input  req,
    input  addr,
    input  wstrb,
    inout  data,
    output gnt,
    output data_gnt
  );
endinterface

// File: rtl/ladybird_timeout_counter.sv
// Wait-cycle counter for bus primaries; expired is high while the count equals TIMEOUT-1.
module ladybird_timeout_counter #(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned CNT_WIDTH = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CNT_WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/ladybird_bus_initiator.sv
// Single-outstanding ladybird_bus primary: one command in, one bus transaction, one response out.
module ladybird_bus_initiator
  import ladybird_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned CNT_WIDTH = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  ladybird_bus_if.primary       bus,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [31:0]           cmd_addr,
  input  logic [3:0]            cmd_wstrb,
  input  logic [BUS_DATA_W-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [BUS_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err
);

  typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;

  state_e state_q, state_d;
  cmd_t   cmd_q, cmd_d;
  rsp_t   rsp_q, rsp_d;
  logic   req_q, req_d;
  logic   cmd_ready_q, cmd_ready_d;
  logic   rsp_valid_q, rsp_valid_d;
  logic   cnt_clear, cnt_en, cnt_expired;
  logic   is_write, done;

  ladybird_timeout_counter #(
    .TIMEOUT   (TIMEOUT),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .expired (cnt_expired)
  );

  assign is_write = (cmd_q.wstrb != 4'h0);
  // Reads need data_gnt; gnt alone only acknowledges the address phase.
  assign done     = is_write ? bus.gnt : bus.data_gnt;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rsp_d       = rsp_q;
    req_d       = req_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          cmd_d       = '{addr: cmd_addr, wstrb: cmd_wstrb, wdata: cmd_wdata};
          cnt_clear   = 1'b1;
          req_d       = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = StReq;
        end
      end
      StReq: begin
        if (done) begin
          rsp_d       = '{rdata: is_write ? '0 : bus.data, err: 1'b0};
          req_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = StRsp;
        end else if (cnt_expired) begin
          rsp_d       = '{rdata: '0, err: 1'b1};
          req_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = StRsp;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StRsp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cmd_q       <= '0;
      rsp_q       <= '0;
      req_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rsp_q       <= rsp_d;
      req_q       <= req_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.req   = req_q;
  assign bus.addr  = cmd_q.addr;
  assign bus.wstrb = cmd_q.wstrb;
  assign bus.data  = (state_q == StReq && is_write) ? cmd_q.wdata : 'z;

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_ladybird_bus_initiator.sv
// Directed bench for ladybird_bus_initiator against a small register-file secondary model.
module tb_ladybird_bus_initiator;

  localparam int unsigned Timeout = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        sec_gnt = 1'b0;
  logic        sec_respond = 1'b0;
  int          sec_delay = 0;
  int          wait_cnt = 0;
  logic [31:0] mem [16];

  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  ladybird_bus_if bus_if ();

  ladybird_bus_initiator #(
    .TIMEOUT (Timeout)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_wstrb (cmd_wstrb),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  // Secondary model: gnt on request, data_gnt for reads after sec_delay wait cycles.
  assign bus_if.gnt      = bus_if.req & sec_gnt;
  assign bus_if.data_gnt = bus_if.req & sec_respond & (bus_if.wstrb == 4'h0) &
                           (wait_cnt == sec_delay);
  assign bus_if.data     = (bus_if.req && bus_if.wstrb == 4'h0 && sec_respond) ?
                           mem[bus_if.addr[5:2]] : 'z;

  always @(posedge clk) begin
    if (!bus_if.req || bus_if.data_gnt) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (bus_if.req && bus_if.gnt && bus_if.wstrb != 4'h0) begin
      for (int b = 0; b < 4; b++) begin
        if (bus_if.wstrb[b]) mem[bus_if.addr[5:2]][8*b +: 8] <= bus_if.data[8*b +: 8];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one command; returns req-high cycles, cycles from handshake to rsp_valid, and the
  // bus data seen in the last req cycle.
  task automatic do_txn(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                        output int req_cyc, output int lat, output logic [31:0] seen);
    cmd_addr  = a;
    cmd_wstrb = s;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    req_cyc = 0;
    seen = '0;
    while (!rsp_valid && lat < 40) begin
      if (bus_if.req) begin
        req_cyc++;
        seen = bus_if.data;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic accept_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_eq({tag, "_cmd_ready_after"}, 32'(cmd_ready), 32'd1);
    check_eq({tag, "_rsp_valid_after"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int          rc, lt;
    logic [31:0] seen;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[1] = 32'h0000_0005;

    #12;
    check_eq("rst_req",       32'(bus_if.req), 32'd0);
    check_eq("rst_addr",      bus_if.addr, 32'd0);
    check_eq("rst_wstrb",     32'(bus_if.wstrb), 32'd0);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rdata",     rsp_rdata, 32'd0);
    check_eq("rst_err",       32'(rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero-wait read of 0x4.
    sec_gnt = 1'b1; sec_respond = 1'b1; sec_delay = 0;
    do_txn(32'h4, 4'h0, 32'h0, rc, lt, seen);
    check_eq("rd0_req_cycles", 32'(rc), 32'd1);
    check_eq("rd0_latency",    32'(lt), 32'd2);
    check_eq("rd0_rdata",      rsp_rdata, 32'h5);
    check_eq("rd0_err",        32'(rsp_err), 32'd0);
    accept_rsp("rd0");

    // Full-word write of 0xA to 0x8.
    do_txn(32'h8, 4'hF, 32'hA, rc, lt, seen);
    check_eq("wr_bus_data",   seen, 32'hA);
    check_eq("wr_req_cycles", 32'(rc), 32'd1);
    check_eq("wr_latency",    32'(lt), 32'd2);
    check_eq("wr_rdata",      rsp_rdata, 32'h0);
    check_eq("wr_err",        32'(rsp_err), 32'd0);
    check_eq("wr_mem",        mem[2], 32'hA);
    accept_rsp("wr");

    do_txn(32'h8, 4'h0, 32'h0, rc, lt, seen);
    check_eq("rdback_rdata", rsp_rdata, 32'hA);
    accept_rsp("rdback");

    // data_gnt three cycles late lands on the last allowed cycle: completion beats timeout.
    sec_delay = 3;
    do_txn(32'h8, 4'h0, 32'h0, rc, lt, seen);
    check_eq("rd3_req_cycles", 32'(rc), 32'd4);
    check_eq("rd3_latency",    32'(lt), 32'd5);
    check_eq("rd3_rdata",      rsp_rdata, 32'hA);
    check_eq("rd3_err",        32'(rsp_err), 32'd0);
    accept_rsp("rd3");

    // gnt but never data_gnt: timeout.
    sec_respond = 1'b0;
    do_txn(32'h4, 4'h0, 32'h0, rc, lt, seen);
    check_eq("to_req_cycles", 32'(rc), Timeout);
    check_eq("to_latency",    32'(lt), Timeout + 1);
    check_eq("to_rdata",      rsp_rdata, 32'h0);
    check_eq("to_err",        32'(rsp_err), 32'd1);
    accept_rsp("to");

    // Response back-pressure with a second command waiting.
    sec_respond = 1'b1; sec_delay = 0;
    do_txn(32'h4, 4'h0, 32'h0, rc, lt, seen);
    check_eq("bp_latency", 32'(lt), 32'd2);
    cmd_addr = 32'h8; cmd_wstrb = 4'h0; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("bp_rdata",     rsp_rdata, 32'h5);
      check_eq("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check_eq("bp_req",       32'(bus_if.req), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_eq("bp_cmd_ready_r1", 32'(cmd_ready), 32'd1);
    check_eq("bp_req_r1",       32'(bus_if.req), 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check_eq("bp2_req",       32'(bus_if.req), 32'd1);
    check_eq("bp2_addr",      bus_if.addr, 32'h8);
    check_eq("bp2_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    check_eq("bp2_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("bp2_rdata",     rsp_rdata, 32'hA);
    accept_rsp("bp2");

    // Asynchronous reset in the middle of REQ.
    sec_respond = 1'b0;
    cmd_addr = 32'h4; cmd_wstrb = 4'h0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check_eq("ar_req_before", 32'(bus_if.req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("ar_req_async",   32'(bus_if.req), 32'd0);
    check_eq("ar_rsp_valid",   32'(rsp_valid), 32'd0);
    check_eq("ar_cmd_ready",   32'(cmd_ready), 32'd1);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    check_eq("ar_post_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("ar_post_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("ar_post_req",       32'(bus_if.req), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
